mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 16, memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_BITS, default $clog2(4*SIZE), byte-address width.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_cpu_req  input  1  pipeline access request, held until ack.
REQ-006 SHALL have port i_cpu_wr  input  1  1=write, 0=read.
REQ-007 SHALL have port i_cpu_addr  input  ADDR_BITS  byte address.
REQ-008 SHALL have port i_cpu_wdata  input  32  write data.
REQ-009 SHALL have port o_cpu_rdata  output  32  read data, valid with ack.
REQ-010 SHALL have port o_cpu_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port o_cpu_err  output  1  one-cycle pulse with ack on out-of-range address.
REQ-012 SHALL have port o_cpu_stall  output  1  pipeline must hold, memory owned by debug.
REQ-013 SHALL have port i_dbg_dump_start  input  1  request full memory dump.
REQ-014 SHALL have port o_dbg_data  output  32  dump word.
REQ-015 SHALL have port o_dbg_valid  output  1  dump word valid.
REQ-016 SHALL have port i_dbg_ready  input  1  debug consumer accepts word.
REQ-017 SHALL have port o_dbg_done  output  1  one-cycle pulse after last word accepted.
REQ-018 SHALL have ports o_mem_addr (ADDR_BITS), o_mem_wr_en (1), o_mem_wdata (32) outputs and i_mem_rdata (32) input to the combinational-read word memory.

Function
REQ-019 SHALL implement FSM states IDLE, CPU_ACC, DUMP_RD, DUMP_HOLD, DUMP_DONE.
REQ-020 IDLE: i_cpu_req=1 -> latch addr/wr/wdata, go CPU_ACC; else pending dump -> DUMP_RD; else stay.
REQ-021 i_dbg_dump_start SHALL set a pending flag in any state except DUMP_*; cleared on entry to DUMP_RD.
REQ-022 Simultaneous i_cpu_req and i_dbg_dump_start in IDLE: CPU served first, dump begins the cycle after CPU_ACC.
REQ-023 CPU_ACC: drive latched address; o_mem_wr_en=latched wr only if addr <= 4*SIZE-4; capture i_mem_rdata (reads) else 0; next cycle o_cpu_ack=1 and state IDLE.
REQ-024 CPU latency SHALL be exactly 2 cycles from req sampled to ack; back-to-back requests allowed (req still high in ack cycle starts a new access).
REQ-025 Out-of-range CPU address (> 4*SIZE-4): no write, o_cpu_rdata=0, o_cpu_err=1 with ack.
REQ-026 DUMP_RD: o_mem_addr=dump counter, o_mem_wr_en=0, capture i_mem_rdata into o_dbg_data, go DUMP_HOLD.
REQ-027 DUMP_HOLD: o_dbg_valid=1, o_dbg_data stable; on i_dbg_ready: counter==4*SIZE-4 -> DUMP_DONE, else counter+=4 -> DUMP_RD.
REQ-028 DUMP_DONE: o_dbg_done=1 one cycle, counter cleared to 0, -> IDLE.
REQ-029 o_cpu_stall SHALL be 1 in DUMP_RD/DUMP_HOLD/DUMP_DONE and whenever dump pending; CPU requests then not acked.
REQ-030 o_mem_wr_en SHALL be 0 in every state except CPU_ACC write.

Reset
REQ-031 rst SHALL force state IDLE, counter 0, pending 0, all outputs 0, in any state including mid-dump or mid-access; an interrupted access SHALL not ack.

Structure
REQ-032 State encoding and WORD_BYTES=4 SHALL live in a shared package.
REQ-033 The dump address counter SHALL be a sub-module addr_stepper (clear, step by 4, last flag).

Verification
REQ-034 Write 0xDEADBEEF @0x08, then read @0x08 -> ack 2 cycles after each req, rdata 0xDEADBEEF, err 0.
REQ-035 Read @0x3D (SIZE=16) -> ack with err=1, rdata 0, no o_mem_wr_en pulse.
REQ-036 Memory preloaded word i = i+1, dump with ready tied 1 -> 16 words 1..16 in order, done pulse once, stall high throughout.
REQ-037 Dump with ready low 5 cycles on word 3 -> o_dbg_data holds 4, valid stays high, no skip.
REQ-038 cpu_req and dump_start same cycle -> CPU ack first, dump word 0 valid 2 cycles later.
REQ-039 rst asserted at dump word 7 -> all outputs 0 next cycle; new dump restarts at address 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and word geometry.
package mem_arbiter_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        DUMP_RD,
        DUMP_HOLD,
        DUMP_DONE
    } state_t;

    function automatic logic is_dump(input state_t s);
        return (s == DUMP_RD) || (s == DUMP_HOLD) || (s == DUMP_DONE);
    endfunction

endpackage

// File: rtl/mem_arbiter_addr_stepper.sv
// Dump address counter: walks byte addresses one word at a time and flags the last word.
module addr_stepper
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int LAST_ADDR = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 last
);

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(LAST_ADDR);
    localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(WORD_BYTES);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            addr <= '0;
        end else if (step) begin
            addr <= addr + STEP;
        end
    end

    assign last = (addr == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port word memory between CPU accesses and a debug full-memory dump.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int ADDR_BITS = $clog2(WORD_BYTES * SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cpu_req,
    input  logic                 i_cpu_wr,
    input  logic [ADDR_BITS-1:0] i_cpu_addr,
    input  logic [31:0]          i_cpu_wdata,
    output logic [31:0]          o_cpu_rdata,
    output logic                 o_cpu_ack,
    output logic                 o_cpu_err,
    output logic                 o_cpu_stall,
    input  logic                 i_dbg_dump_start,
    output logic [31:0]          o_dbg_data,
    output logic                 o_dbg_valid,
    input  logic                 i_dbg_ready,
    output logic                 o_dbg_done,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic                 o_mem_wr_en,
    output logic [31:0]          o_mem_wdata,
    input  logic [31:0]          i_mem_rdata
);

    localparam int LAST_INT = WORD_BYTES * SIZE - WORD_BYTES;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(LAST_INT);

    state_t                 state;
    logic                   pending;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   wr_q;
    logic [31:0]            wdata_q;
    logic [ADDR_BITS-1:0]   dump_addr;
    logic                   dump_last;
    logic                   in_range;
    logic                   dump_step;
    logic                   dump_clear;

    assign in_range   = (addr_q <= LAST_ADDR);
    assign dump_step  = (state == DUMP_HOLD) && i_dbg_ready && !dump_last;
    assign dump_clear = (state == DUMP_DONE);

    addr_stepper #(
        .ADDR_BITS (ADDR_BITS),
        .LAST_ADDR (LAST_INT)
    ) u_stepper (
        .clk   (clk),
        .rst   (rst),
        .clear (dump_clear),
        .step  (dump_step),
        .addr  (dump_addr),
        .last  (dump_last)
    );

    // Memory port is steered purely from registered state, so nothing reaches it outside an access.
    assign o_mem_addr  = (state == CPU_ACC) ? addr_q :
                         (state == DUMP_RD) ? dump_addr : '0;
    assign o_mem_wr_en = (state == CPU_ACC) && wr_q && in_range;
    assign o_mem_wdata = (state == CPU_ACC) ? wdata_q : '0;
    assign o_cpu_stall = pending || is_dump(state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            o_cpu_rdata <= '0;
            o_cpu_ack   <= 1'b0;
            o_cpu_err   <= 1'b0;
            o_dbg_data  <= '0;
            o_dbg_valid <= 1'b0;
            o_dbg_done  <= 1'b0;
        end else begin
            o_cpu_ack  <= 1'b0;
            o_cpu_err  <= 1'b0;
            o_dbg_done <= 1'b0;
            if (i_dbg_dump_start && !is_dump(state)) begin
                pending <= 1'b1;
            end
            // An already-pending dump outranks a CPU request; a same-cycle start lets the CPU go first.
            case (state)
                IDLE: begin
                    if (pending) begin
                        pending <= 1'b0;
                        state   <= DUMP_RD;
                    end else if (i_cpu_req) begin
                        addr_q  <= i_cpu_addr;
                        wr_q    <= i_cpu_wr;
                        wdata_q <= i_cpu_wdata;
                        state   <= CPU_ACC;
                    end
                end
                CPU_ACC: begin
                    o_cpu_ack   <= 1'b1;
                    o_cpu_err   <= !in_range;
                    o_cpu_rdata <= (in_range && !wr_q) ? i_mem_rdata : '0;
                    state       <= IDLE;
                end
                DUMP_RD: begin
                    o_dbg_data  <= i_mem_rdata;
                    o_dbg_valid <= 1'b1;
                    state       <= DUMP_HOLD;
                end
                DUMP_HOLD: begin
                    if (i_dbg_ready) begin
                        o_dbg_valid <= 1'b0;
                        if (dump_last) begin
                            o_dbg_done <= 1'b1;
                            state      <= DUMP_DONE;
                        end else begin
                            state <= DUMP_RD;
                        end
                    end
                end
                DUMP_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random and directed CPU traffic plus debug dumps
// checked against a word-array reference model.
module tb_mem_arbiter;

    localparam int SIZE = 16;
    localparam int AW   = 6;
    localparam logic [AW-1:0] LAST = 6'd60;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          exp_cyc;
    } cpu_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_ack;
    logic          cpu_err;
    logic          cpu_stall;
    logic          dbg_dump_start;
    logic [31:0]   dbg_data;
    logic          dbg_valid;
    logic          dbg_ready;
    logic          dbg_done;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          preload;
    logic [127:0]  all_outs;

    logic [31:0] mem [SIZE];
    logic [31:0] ref_mem [SIZE];
    cpu_exp_t    cpu_q [$];
    logic [31:0] dbg_q [$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int bad_wr = 0;
    int done_cnt = 0;
    int exp_writes = 0;
    int last_ack_cyc = 0;
    int last_done_cyc = 0;
    int ready_mode = 1;

    mem_arbiter #(.SIZE(SIZE)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_cpu_req        (cpu_req),
        .i_cpu_wr         (cpu_wr),
        .i_cpu_addr       (cpu_addr),
        .i_cpu_wdata      (cpu_wdata),
        .o_cpu_rdata      (cpu_rdata),
        .o_cpu_ack        (cpu_ack),
        .o_cpu_err        (cpu_err),
        .o_cpu_stall      (cpu_stall),
        .i_dbg_dump_start (dbg_dump_start),
        .o_dbg_data       (dbg_data),
        .o_dbg_valid      (dbg_valid),
        .i_dbg_ready      (dbg_ready),
        .o_dbg_done       (dbg_done),
        .o_mem_addr       (mem_addr),
        .o_mem_wr_en      (mem_wr_en),
        .o_mem_wdata      (mem_wdata),
        .i_mem_rdata      (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational-read word memory standing in for the real RAM.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < SIZE; i++) mem[i] <= 32'(i + 1);
        end else if (mem_wr_en) begin
            mem[int'(mem_addr) / 4] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[int'(mem_addr) / 4];

    assign all_outs = {20'd0, cpu_rdata, cpu_ack, cpu_err, cpu_stall, dbg_data, dbg_valid,
                       dbg_done, mem_addr, mem_wr_en, mem_wdata};

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout/unexpected expected event", name);
    endtask

    // Issue one CPU access and hold req until acked; expectation comes from the word-array model.
    task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                                 input bit chk_lat);
        cpu_exp_t e;
        bit got;
        e.err     = (addr > LAST);
        e.rdata   = (!e.err && !wr) ? ref_mem[int'(addr) / 4] : 32'd0;
        e.exp_cyc = chk_lat ? cyc + 2 : -1;
        if (wr && !e.err) begin
            ref_mem[int'(addr) / 4] = wdata;
            exp_writes++;
        end
        cpu_q.push_back(e);
        cpu_req   = 1'b1;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        got = 1'b0;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        if (!got) begin
            failNow("cpu_ack_timeout");
            e = cpu_q.pop_back();
        end
    endtask

    task automatic dumpRun(input int first_lat);
        int n, first, stall_low, done_before;
        bit seen;
        n = cyc;
        first = -1;
        stall_low = 0;
        done_before = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < SIZE; i++) dbg_q.push_back(ref_mem[i]);
        dbg_dump_start = 1'b1;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            dbg_dump_start = 1'b0;
            if (!cpu_stall) stall_low++;
            if (dbg_valid && first < 0) first = cyc;
            if (dbg_done) seen = 1'b1;
        end
        if (!seen) failNow("dump_done_timeout");
        checkOutput("dump_stall_low_cycles", stall_low, 0);
        checkOutput("dump_first_valid_cycle", first, n + first_lat);
        @(negedge clk);
        checkOutput("dump_done_pulses", done_cnt - done_before, 1);
        checkOutput("dump_words_left", dbg_q.size(), 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        preload = 1'b1;
        cpu_req = 1'b0;
        dbg_dump_start = 1'b0;
        @(negedge clk);
        preload = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < SIZE; i++) ref_mem[i] = 32'(i + 1);
        cpu_q.delete();
        dbg_q.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Debug consumer: changes ready just after each rising edge so the monitor sees it settled.
    initial begin
        int low_cnt;
        low_cnt = 0;
        dbg_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: begin dbg_ready = 1'b0; low_cnt = 0; end
                2: begin dbg_ready = 1'($urandom % 2); low_cnt = 0; end
                3: begin
                    if (dbg_valid && dbg_data == 32'd4 && low_cnt < 5) begin
                        dbg_ready = 1'b0;
                        low_cnt++;
                    end else begin
                        dbg_ready = 1'b1;
                    end
                end
                default: begin dbg_ready = 1'b1; low_cnt = 0; end
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT presents a CPU ack or a dump handshake.
    initial begin
        bit pv, pr;
        logic [31:0] pd;
        cpu_exp_t e;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (cpu_ack) begin
                    last_ack_cyc = cyc;
                    if (cpu_q.size() == 0) begin
                        failNow("unexpected_cpu_ack");
                    end else begin
                        e = cpu_q.pop_front();
                        checkOutput("cpu_rdata", cpu_rdata, e.rdata);
                        checkOutput("cpu_err", cpu_err, e.err);
                        if (e.exp_cyc >= 0) checkOutput("cpu_ack_cycle", cyc, e.exp_cyc);
                    end
                end
                if (mem_wr_en) begin
                    wr_cnt++;
                    if (mem_addr > LAST) bad_wr++;
                end
                if (dbg_done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
                if (pv && !pr) checkOutput("dbg_hold", {dbg_valid, dbg_data}, {1'b1, pd});
                if (dbg_valid && dbg_ready) begin
                    if (dbg_q.size() == 0) failNow("unexpected_dbg_word");
                    else checkOutput("dbg_data", dbg_data, dbg_q.pop_front());
                end
                pv = dbg_valid;
                pr = dbg_ready;
                pd = dbg_data;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        dbg_dump_start = 1'b0;
        preload = 1'b0;

        resetDut();
        checkOutput("reset_outputs", all_outs, '0);

        applyStimulus(1'b1, 6'h08, 32'hDEADBEEF, 1'b1);
        applyStimulus(1'b0, 6'h08, 32'h0, 1'b1);
        applyStimulus(1'b0, 6'h3D, 32'h0, 1'b1);
        applyStimulus(1'b1, 6'h3E, 32'h12345678, 1'b1);
        applyStimulus(1'b1, 6'h3C, 32'hA5A5F00D, 1'b1);
        applyStimulus(1'b0, 6'h3C, 32'h0, 1'b1);
        applyStimulus(1'b0, 6'h3F, 32'h0, 1'b1);
        applyStimulus(1'b0, 6'h00, 32'h0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom % 2), AW'($urandom_range(0, 63)), $urandom, 1'b1);
        end

        resetDut();
        ready_mode = 1;
        dumpRun(3);

        ready_mode = 3;
        dumpRun(3);

        ready_mode = 2;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom % 2), AW'($urandom_range(0, 63)), $urandom, 1'b1);
        end
        dumpRun(3);
        ready_mode = 1;

        fork
            applyStimulus(1'b0, 6'h14, 32'h0, 1'b1);
            dumpRun(4);
        join

        fork
            dumpRun(3);
            begin
                repeat (5) @(negedge clk);
                applyStimulus(1'b1, 6'h20, 32'hCAFE0123, 1'b0);
            end
        join
        checkOutput("ack_after_dump_done", last_ack_cyc > last_done_cyc, 1'b1);
        applyStimulus(1'b0, 6'h20, 32'h0, 1'b1);

        cpu_req = 1'b1;
        cpu_wr = 1'b0;
        cpu_addr = 6'h08;
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_access_ack", cpu_ack, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        resetDut();
        for (int i = 0; i < SIZE; i++) dbg_q.push_back(ref_mem[i]);
        dbg_dump_start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            dbg_dump_start = 1'b0;
            if (dbg_valid && dbg_data == 32'd8) found = 1'b1;
        end
        if (!found) failNow("dump_word7_timeout");
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_dump_outputs", all_outs, '0);
        rst = 1'b0;
        dbg_q.delete();
        @(negedge clk);
        dumpRun(3);

        checkOutput("mem_write_pulses", wr_cnt, exp_writes);
        checkOutput("out_of_range_writes", bad_wr, 0);
        checkOutput("cpu_expect_left", cpu_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
